// File: rtl/ctrl_pkg.sv
// Shared issue-control types: FSM state encoding and the default in-flight cap.
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_CTRL = 2'd1,
    FLUSH     = 2'd2
  } ctrl_state_e;

  localparam int unsigned MAX_INFLIGHT_DEF = 3;

endpackage

// File: rtl/define.sv
// Global RV64 pipeline defines shared by the issue controller and its bench.
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

// File: rtl/sb_cnt_array.sv
// Per-register pending-write counters for x1..x31 with source read ports.
// x0 is never tracked; a same-register inc/dec pair cancels out.
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

module sb_cnt_array #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned AW    = `REG_ADDRW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  input  logic [AW-1:0] i_inc_id,
  input  logic          i_dec,
  input  logic [AW-1:0] i_dec_id,
  input  logic [AW-1:0] i_rs1id,
  input  logic [AW-1:0] i_rs2id,
  output logic          o_rs1_busy,
  output logic          o_rs2_busy,
  output logic          o_underflow
);

  localparam int unsigned NREG = 1 << AW;

  logic [CNT_W-1:0] r_cnt [1:NREG-1];
  logic [NREG-1:1]  w_inc_hit;
  logic [NREG-1:1]  w_dec_hit;
  logic [NREG-1:0]  w_busy;

  always_comb begin
    w_inc_hit = '0;
    w_dec_hit = '0;
    w_busy    = '0;
    for (int i = 1; i < NREG; i++) begin
      w_inc_hit[i] = i_inc && (i_inc_id == AW'(i));
      w_dec_hit[i] = i_dec && (i_dec_id == AW'(i));
      w_busy[i]    = (r_cnt[i] != '0);
    end
  end

  // Bit 0 of w_busy stays 0, so x0 sources never report a hazard.
  assign o_rs1_busy  = w_busy[i_rs1id];
  assign o_rs2_busy  = w_busy[i_rs2id];
  assign o_underflow = i_dec && (i_dec_id != '0) && !w_busy[i_dec_id] &&
                       !(i_inc && (i_inc_id == i_dec_id));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_inc_hit[i] && !w_dec_hit[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec_hit[i] && !w_inc_hit[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Scoreboard issue controller: RAW blocking, in-flight cap, control serialisation.
// Optional perf counters are enabled with the ISSUE_CTRL_PERF_EN macro.
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

module issue_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [`REG_ADDRW-1:0] i_id_rs1id,
  input  logic [`REG_ADDRW-1:0] i_id_rs2id,
  input  logic [`REG_ADDRW-1:0] i_id_rdid,
  input  logic                  i_id_rdwen,
  input  logic                  i_id_ctrl,
  input  logic                  i_ex_ready,
  input  logic                  i_ex_resolve,
  input  logic                  i_ex_redirect,
  input  logic                  i_wb_valid,
  input  logic                  i_wb_rdwen,
  input  logic [`REG_ADDRW-1:0] i_wb_rdid,
  output logic                  o_id_ready,
  output logic                  o_issue_valid,
  output logic                  o_flush,
`ifdef ISSUE_CTRL_PERF_EN
  output logic [31:0]           o_perf_stall_raw,
  output logic [31:0]           o_perf_stall_ctrl,
  output logic [31:0]           o_perf_flush,
`endif
  output logic                  o_sb_err
);

  ctrl_state_e      r_state, w_state_d;
  logic [CNT_W-1:0] r_inflight, w_inflight_d;
  logic             r_sb_err;
  logic             w_rs1_busy, w_rs2_busy, w_raw;
  logic             w_id_ready, w_issue;
  logic             w_cnt_uf, w_infl_uf;

  sb_cnt_array #(
    .CNT_W (CNT_W),
    .AW    (`REG_ADDRW)
  ) u_sb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_inc       (w_issue && i_id_rdwen),
    .i_inc_id    (i_id_rdid),
    .i_dec       (i_wb_valid && i_wb_rdwen),
    .i_dec_id    (i_wb_rdid),
    .i_rs1id     (i_id_rs1id),
    .i_rs2id     (i_id_rs2id),
    .o_rs1_busy  (w_rs1_busy),
    .o_rs2_busy  (w_rs2_busy),
    .o_underflow (w_cnt_uf)
  );

  assign w_raw      = w_rs1_busy || w_rs2_busy;
  assign w_id_ready = (r_state == RUN) && i_ex_ready && !w_raw &&
                      (r_inflight < CNT_W'(MAX_INFLIGHT));
  assign w_issue    = i_id_valid && w_id_ready;

  assign o_id_ready    = w_id_ready;
  assign o_issue_valid = w_issue;
  assign o_flush       = (r_state == FLUSH);
  assign o_sb_err      = r_sb_err;

  always_comb begin
    w_inflight_d = r_inflight;
    w_infl_uf    = 1'b0;
    if (w_issue && !i_wb_valid) begin
      w_inflight_d = r_inflight + 1'b1;
    end else if (!w_issue && i_wb_valid) begin
      if (r_inflight == '0) w_infl_uf = 1'b1;
      else                  w_inflight_d = r_inflight - 1'b1;
    end
  end

  // Resolve is only meaningful while a control instruction is outstanding.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      RUN:       if (w_issue && i_id_ctrl) w_state_d = WAIT_CTRL;
      WAIT_CTRL: if (i_ex_resolve) w_state_d = i_ex_redirect ? FLUSH : RUN;
      FLUSH:     w_state_d = RUN;
      default:   w_state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RUN;
      r_inflight <= '0;
      r_sb_err   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_inflight <= w_inflight_d;
      r_sb_err   <= r_sb_err | w_cnt_uf | w_infl_uf;
    end
  end

`ifdef ISSUE_CTRL_PERF_EN
  logic [31:0] r_perf_stall_raw, r_perf_stall_ctrl, r_perf_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_stall_raw  <= '0;
      r_perf_stall_ctrl <= '0;
      r_perf_flush      <= '0;
    end else begin
      if (i_id_valid && w_raw)              r_perf_stall_raw  <= r_perf_stall_raw + 1'b1;
      if (i_id_valid && (r_state != RUN))   r_perf_stall_ctrl <= r_perf_stall_ctrl + 1'b1;
      if (r_state == FLUSH)                 r_perf_flush      <= r_perf_flush + 1'b1;
    end
  end

  assign o_perf_stall_raw  = r_perf_stall_raw;
  assign o_perf_stall_ctrl = r_perf_stall_ctrl;
  assign o_perf_flush      = r_perf_flush;
`endif

endmodule
